// File: rtl/regfile_pkg.sv
// Shared constants and types for the dual-issue GPR file.
// The read ports and the storage top both import this package.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int NREGS    = 32;
  localparam int ADDR_W   = $clog2(NREGS);
  localparam int ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: applies the $zero rule and the WB->ID bypass,
// then selects the addressed entry from storage.
module regfile_read_port import regfile_pkg::*; #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NREGS,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]             raddr,
  input  logic [NREGS-1:0][DATA_W-1:0]  regs,
  input  logic                          wr0,
  input  logic [ADDR_W-1:0]             waddr0,
  input  logic [DATA_W-1:0]             wdata0,
  input  logic                          wr1,
  input  logic [ADDR_W-1:0]             waddr1,
  input  logic [DATA_W-1:0]             wdata1,
  output logic [DATA_W-1:0]             rdata
);

  // Slot 1 is checked last so the younger write wins the bypass; $zero overrides all.
  always_comb begin
    rdata = regs[raddr];
    if (BYPASS != 0) begin
      if (wr0 && (waddr0 == raddr)) rdata = wdata0;
      if (wr1 && (waddr1 == raddr)) rdata = wdata1;
    end
    if (raddr == ADDR_W'(ZERO_REG)) rdata = '0;
  end

endmodule

// File: rtl/reg_file_2w4r.sv
// 32 x 32 architectural register file: two write ports (slot 1 wins on a clash),
// four combinational read ports with optional same-cycle bypass.
module reg_file_2w4r import regfile_pkg::*; #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NREGS,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] raddr3,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3,
  output logic              wr_clash
);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         wr0;
  logic                         wr1;
  logic                         byp0;
  logic                         byp1;
  logic [3:0][ADDR_W-1:0]       raddr_v;
  logic [3:0][DATA_W-1:0]       rdata_v;

  // A write only commits when enabled and not aimed at $zero.
  assign wr0 = we0 && (waddr0 != ADDR_W'(ZERO_REG));
  assign wr1 = we1 && (waddr1 != ADDR_W'(ZERO_REG));

  // Writes in flight during reset are lost, so they must not be bypassed either.
  assign byp0 = wr0 && rst_n;
  assign byp1 = wr1 && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '0;
      wr_clash <= 1'b0;
    end else begin
      if (wr0) regs[waddr0] <= wdata0;
      if (wr1) regs[waddr1] <= wdata1;
      wr_clash <= wr0 && wr1 && (waddr0 == waddr1);
    end
  end

  assign raddr_v = {raddr3, raddr2, raddr1, raddr0};

  for (genvar i = 0; i < 4; i++) begin : g_rd
    regfile_read_port #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .raddr  (raddr_v[i]),
      .regs   (regs),
      .wr0    (byp0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .wr1    (byp1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .rdata  (rdata_v[i])
    );
  end

  assign rdata0 = rdata_v[0];
  assign rdata1 = rdata_v[1];
  assign rdata2 = rdata_v[2];
  assign rdata3 = rdata_v[3];

endmodule

// File: tb/tb_reg_file_2w4r.sv
// Bench for reg_file_2w4r: directed vector table, mid-write reset sequence,
// and a randomized run against an array-based reference model.
module tb_reg_file_2w4r;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int N_RANDOM = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we0 = 1'b0;
  logic [AW-1:0] wa0 = '0;
  logic [DW-1:0] wd0 = '0;
  logic          we1 = 1'b0;
  logic [AW-1:0] wa1 = '0;
  logic [DW-1:0] wd1 = '0;
  logic [AW-1:0] ra [4];
  logic [DW-1:0] rd [4];
  logic          wr_clash;

  int n_checks = 0;
  int n_pass = 0;

  logic [DW-1:0] model [NR];
  logic          model_clash;
  logic [DW-1:0] exp_q [$];

  typedef struct packed {
    logic               we0;
    logic [AW-1:0]      wa0;
    logic [DW-1:0]      wd0;
    logic               we1;
    logic [AW-1:0]      wa1;
    logic [DW-1:0]      wd1;
    logic [3:0][AW-1:0] ra;
    logic [3:0][DW-1:0] er;
    logic               eclash;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  reg_file_2w4r #(
    .DATA_W (DW),
    .NREGS  (NR),
    .ADDR_W (AW),
    .BYPASS (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we0      (we0),
    .waddr0   (wa0),
    .wdata0   (wd0),
    .we1      (we1),
    .waddr1   (wa1),
    .wdata1   (wd1),
    .raddr0   (ra[0]),
    .raddr1   (ra[1]),
    .raddr2   (ra[2]),
    .raddr3   (ra[3]),
    .rdata0   (rd[0]),
    .rdata1   (rd[1]),
    .rdata2   (rd[2]),
    .rdata3   (rd[3]),
    .wr_clash (wr_clash)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic [AW-1:0] r0, input logic [AW-1:0] r1,
    input logic [AW-1:0] r2, input logic [AW-1:0] r3,
    input logic [DW-1:0] e0, input logic [DW-1:0] e1,
    input logic [DW-1:0] e2, input logic [DW-1:0] e3,
    input logic ec);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
    v.er[0] = e0; v.er[1] = e1; v.er[2] = e2; v.er[3] = e3;
    v.eclash = ec;
    return v;
  endfunction

  // Expected read: $zero, then younger write, then older write, then storage.
  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return model[a];
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  // Entered just after a rising edge; reads are sampled mid-cycle, wr_clash after the edge.
  task automatic apply_vec(input vec_t v, input int idx);
    we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
    we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
    for (int i = 0; i < 4; i++) ra[i] = v.ra[i];
    #4;
    for (int i = 0; i < 4; i++)
      check($sformatf("vec%0d rdata%0d", idx, i), rd[i], v.er[i]);
    @(posedge clk); #1;
    check($sformatf("vec%0d wr_clash", idx), {31'b0, wr_clash}, {31'b0, v.eclash});
  endtask

  task automatic sweep_zero(input string tag);
    for (int a = 0; a < NR; a += 4) begin
      for (int i = 0; i < 4; i++) ra[i] = AW'(a + i);
      #1;
      for (int i = 0; i < 4; i++)
        check($sformatf("%s addr%0d", tag, a + i), rd[i], '0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ra[i] = '0;

    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  4, 0, 5, 0,
                  32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);
    vecs[1]  = mk(0, 0, 32'h0, 0, 0, 32'h0,  5, 4, 5, 0,
                  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);
    vecs[2]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF,  0, 0, 0, 0,
                  32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    vecs[3]  = mk(0, 0, 32'h0, 0, 0, 32'h0,  0, 5, 0, 0,
                  32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
    vecs[4]  = mk(1, 7, 32'h11111111, 1, 7, 32'h22222222,  7, 7, 5, 0,
                  32'h22222222, 32'h22222222, 32'hDEADBEEF, 32'h0, 1'b1);
    vecs[5]  = mk(0, 0, 32'h0, 0, 0, 32'h0,  7, 0, 7, 5,
                  32'h22222222, 32'h0, 32'h22222222, 32'hDEADBEEF, 1'b0);
    vecs[6]  = mk(1, 9, 32'hAAAA0000, 0, 0, 32'h0,  9, 9, 7, 0,
                  32'hAAAA0000, 32'hAAAA0000, 32'h22222222, 32'h0, 1'b0);
    vecs[7]  = mk(0, 0, 32'h0, 1, 9, 32'h0000BBBB,  9, 9, 7, 5,
                  32'h0000BBBB, 32'h0000BBBB, 32'h22222222, 32'hDEADBEEF, 1'b0);
    vecs[8]  = mk(0, 0, 32'h0, 0, 0, 32'h0,  9, 7, 5, 0,
                  32'h0000BBBB, 32'h22222222, 32'hDEADBEEF, 32'h0, 1'b0);
    vecs[9]  = mk(1, 3, 32'h01234567, 1, 4, 32'h89ABCDEF,  3, 4, 9, 0,
                  32'h01234567, 32'h89ABCDEF, 32'h0000BBBB, 32'h0, 1'b0);
    vecs[10] = mk(0, 0, 32'h0, 0, 0, 32'h0,  3, 4, 7, 9,
                  32'h01234567, 32'h89ABCDEF, 32'h22222222, 32'h0000BBBB, 1'b0);

    // Power-on reset state.
    repeat (2) @(posedge clk);
    #1;
    sweep_zero("por");
    check("por wr_clash", {31'b0, wr_clash}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) apply_vec(vecs[i], i);

    // Clash cycle so wr_clash is high when reset lands mid-write.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h33333333;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h44444444;
    @(posedge clk); #1;
    check("pre-reset wr_clash", {31'b0, wr_clash}, 32'd1);
    we0 = 1'b1; wa0 = 5'd12; wd0 = 32'hCAFEF00D;
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h0BADBEEF;
    ra[0] = 5'd5; ra[1] = 5'd7; ra[2] = 5'd9; ra[3] = 5'd12;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("async reset rdata%0d", i), rd[i], '0);
    check("async reset wr_clash", {31'b0, wr_clash}, '0);
    @(posedge clk); #1;
    we0 = 1'b0; we1 = 1'b0;
    sweep_zero("mid reset");
    check("mid reset wr_clash", {31'b0, wr_clash}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ra[0] = 5'd12; ra[1] = 5'd7;
    #1;
    check("lost write reg12", rd[0], '0);
    check("cleared reg7", rd[1], '0);
    check("post reset wr_clash", {31'b0, wr_clash}, '0);
    @(posedge clk); #1;

    for (int i = 0; i < NR; i++) model[i] = '0;
    for (int c = 0; c < N_RANDOM; c++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = rand_addr(); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = rand_addr(); wd1 = $urandom;
      for (int i = 0; i < 4; i++) ra[i] = rand_addr();
      for (int i = 0; i < 4; i++) exp_q.push_back(ref_read(ra[i]));
      model_clash = we0 && we1 && (wa0 == wa1) && (wa0 != 0);
      #4;
      for (int i = 0; i < 4; i++)
        check($sformatf("rand c%0d rdata%0d", c, i), rd[i], exp_q.pop_front());
      @(posedge clk);
      if (we0 && wa0 != 0) model[wa0] = wd0;
      if (we1 && wa1 != 0) model[wa1] = wd1;
      #1;
      check($sformatf("rand c%0d wr_clash", c), {31'b0, wr_clash}, {31'b0, model_clash});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
